div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It complements the three-stage pipelined multiplier: it sits beside it in execute, takes operands from the same source buses, and returns one result per operation through a start/busy/done handshake. It stalls the pipeline via BUSY and handles the RISC-V divide-by-zero and signed-overflow cases in hardware.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- nrst  input  1  reset, asynchronous assert, active-low.
- EN  input  1  start request, sampled on clk.
- DIV_OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- RS1  input  32  dividend.
- RS2  input  32  divisor.
- RESULT  output  32  quotient or remainder, per captured DIV_OP.
- BUSY  output  1  high while an operation is in flight; reset 0.
- DONE  output  1  one-cycle pulse when RESULT is valid; reset 0.
- FLUSH  input  1  abort; present only with DIV_FLUSH_EN.

## Operation
- States: IDLE, SETUP, ITER, FIN. The reset state is IDLE, with RESULT = 0, BUSY = 0, DONE = 0, and the counter at 0.
- IDLE/FIN with EN = 1:
  - Latch RS1, RS2 and DIV_OP.
  - Go to SETUP.
  - EN in any other state is ignored; no queuing.
- SETUP:
  - Signed ops: take the absolute values of both operands.
  - Record neg_q = sign(RS1) xor sign(RS2) and neg_r = sign(RS1).
  - Unsigned ops: neg_q = neg_r = 0.
  - Detect the special cases:
    - Divide by zero (RS2 = 0): Q = 0xFFFFFFFF, R = RS1.
    - Signed overflow (DIV/REM with RS1 = 0x80000000, RS2 = 0xFFFFFFFF): Q = 0x80000000, R = 0.
  - Special case: go to FIN with the result preloaded, skipping ITER. Otherwise load counter = 31 and go to ITER.
- ITER, one restoring step per cycle:
  - Compute {rem, quo} shifted left by 1, then trial = rem − divisor (33-bit).
  - Trial non-negative: rem = trial, quo bit 0 = 1. Otherwise keep rem, quo bit 0 = 0.
  - Leave to FIN after the step at counter = 0; the counter decrements otherwise.
- FIN:
  - Quotient negated (two's complement) if neg_q; remainder negated if neg_r.
  - RESULT = quotient for DIV/DIVU, remainder for REM/REMU.
  - DONE = 1 for this cycle only. Next state is IDLE, or SETUP if EN = 1.
- RESULT holds its last value until the next FIN.

## Timing
- EN sampled high at edge T:
  - SETUP in cycle T+1, ITER in T+2..T+33, FIN in T+34.
  - DONE and RESULT are valid in cycle T+34.
  - Special cases: FIN, with DONE, in T+2.
- BUSY = 1 from T+1 through FIN inclusive. It stays 1 across back-to-back operations.
- Back-to-back: EN in the FIN cycle starts the next SETUP on the following cycle, with no idle bubble.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at their reset values. No DONE is produced for the aborted operation.
- Operand changes on RS1/RS2 after the EN edge have no effect.

## Configuration
- DIV_FLUSH_EN defined:
  - Adds the FLUSH input.
  - FLUSH = 1 at any edge forces IDLE next cycle, with BUSY = 0 and DONE suppressed; RESULT is unchanged.
  - FLUSH has priority over EN in the same cycle.
- Undefined: no FLUSH port. Every accepted operation runs to completion.

## Structure
- The shared package div_pkg holds:
  - the div_op_e enum (DIV, DIVU, REM, REMU);
  - the div_state_e enum (IDLE, SETUP, ITER, FIN);
  - the constants DIV_ITERS = 32, DIV_OVF_Q = 0x80000000 and DIV_ZERO_Q = 0xFFFFFFFF.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in div_iter.

## Test plan
- DIVU 100 / 7 -> RESULT 14 at T+34, DONE one cycle, BUSY high T+1..T+34.
- REM −7 / 2 (0xFFFFFFF9, 2) -> RESULT 0xFFFFFFFF (−1); DIV same operands -> 0xFFFFFFFD (−3).
- DIV 5 / 0 -> 0xFFFFFFFF at T+2; REMU 5 / 0 -> 5 at T+2.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+2; REM same operands -> 0.
- Back-to-back: EN asserted in the FIN cycle with DIVU 0xFFFFFFFF / 1 -> first result correct, second RESULT 0xFFFFFFFF 34 cycles later, BUSY never drops; EN pulsed during ITER is ignored.
- nrst pulsed at T+10 -> BUSY/DONE/RESULT 0 immediately, no DONE afterwards. With DIV_FLUSH_EN, FLUSH at T+10 -> IDLE at T+11, no DONE, RESULT retains its prior value.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    ITER  = 2'b10,
    FIN   = 2'b11
  } div_state_e;

  localparam int          DIV_ITERS  = 32;
  localparam int          DIV_CNT_W  = 5;
  localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_iter_if.sv
// Start/busy/done handshake bundle between execute and the divider.
// Optional FLUSH wire is present only when DIV_FLUSH_EN is defined.
interface div_iter_if #(parameter int XLEN = 32);

  logic            EN;
  logic [1:0]      DIV_OP;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;
  logic            DONE;
`ifdef DIV_FLUSH_EN
  logic            FLUSH;
`endif

  modport master (
`ifdef DIV_FLUSH_EN
    output FLUSH,
`endif
    output EN, DIV_OP, RS1, RS2,
    input  RESULT, BUSY, DONE
  );

  modport slave (
`ifdef DIV_FLUSH_EN
    input  FLUSH,
`endif
    input  EN, DIV_OP, RS1, RS2,
    output RESULT, BUSY, DONE
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} pair.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic [XLEN-1:0] next_quo
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The shifted remainder needs XLEN+1 bits for the compare, but the
  // difference always fits in XLEN bits once the trial succeeds.
  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    fits     = (rem_sh >= {1'b0, divisor});
    diff     = rem_sh[XLEN-1:0] - divisor;
    next_rem = fits ? diff : rem_sh[XLEN-1:0];
    next_quo = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_FLUSH_EN to add the FLUSH abort input.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       nrst,
  div_iter_if.slave  bus
);

  div_state_e           state, next_state;
  div_op_e              op_q;
  logic [XLEN-1:0]      a_q, b_q;
  logic [XLEN-1:0]      rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0]      result_q, fin_value;
  logic [XLEN-1:0]      step_rem, step_quo;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 q_neg, r_neg;
  logic                 flush, start, load_result;
  logic                 is_signed, is_rem, div_zero, sgn_ovf, special;
  logic                 busy, done;

`ifdef DIV_FLUSH_EN
  assign flush = bus.FLUSH;
`else
  assign flush = 1'b0;
`endif

  assign start     = ((state == IDLE) || (state == FIN)) && bus.EN;
  assign is_signed = (op_q == DIV) || (op_q == REM);
  assign is_rem    = (op_q == REM) || (op_q == REMU);
  assign div_zero  = (b_q == '0);
  assign sgn_ovf   = is_signed && (a_q == DIV_OVF_Q) && (b_q == '1);
  assign special   = div_zero || sgn_ovf;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.EN) next_state = SETUP;
      SETUP:   next_state = special ? FIN : ITER;
      ITER:    if (cnt_q == '0) next_state = FIN;
      FIN:     next_state = bus.EN ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.RESULT = result_q;

  // The final value is formed on the edge that enters FIN, so RESULT is
  // already valid during the DONE cycle and then simply holds.
  assign load_result = !flush &&
                       (((state == SETUP) && special) ||
                        ((state == ITER) && (cnt_q == '0)));

  always_comb begin
    fin_value = '0;
    if (state == SETUP) begin
      if (div_zero) fin_value = is_rem ? a_q : DIV_ZERO_Q;
      else          fin_value = is_rem ? '0  : DIV_OVF_Q;
    end else if (is_rem) begin
      fin_value = r_neg ? -step_rem : step_rem;
    end else begin
      fin_value = q_neg ? -step_quo : step_quo;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q     <= DIV;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else begin
      if (start && !flush) begin
        a_q  <= bus.RS1;
        b_q  <= bus.RS2;
        op_q <= div_op_e'(bus.DIV_OP);
      end
      if (state == SETUP) begin
        q_neg  <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        r_neg  <= is_signed && a_q[XLEN-1];
        rem_q  <= '0;
        quo_q  <= (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
        dvsr_q <= (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
        cnt_q  <= DIV_CNT_W'(DIV_ITERS - 1);
      end else if (state == ITER) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (load_result) result_q <= fin_value;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed self-checking bench for div_iter.
module tb_div_iter;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_iter_if bus ();

  div_iter u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural RV32M result, straight from the instruction definition.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn = !op[0];
    bit rem = op[1];
    int sa, sb;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Called at a negedge; returns at the negedge of the SETUP cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.EN     = 1'b1;
    bus.DIV_OP = op;
    bus.RS1    = a;
    bus.RS2    = b;
    @(negedge clk);
    bus.EN  = 1'b0;
    bus.RS1 = $urandom;
    bus.RS2 = $urandom;
  endtask

  // Walks cycles from SETUP until DONE, returning at the DONE negedge.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat, input bit pulse_en);
    int k = 1;
    bit busy_drop = 1'b0;
    while (bus.DONE !== 1'b1 && k <= 40) begin
      if (bus.BUSY !== 1'b1) busy_drop = 1'b1;
      if (pulse_en && k == 10) begin
        bus.EN     = 1'b1;
        bus.DIV_OP = 2'($urandom);
        bus.RS1    = $urandom;
        bus.RS2    = $urandom;
      end else begin
        bus.EN = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.EN = 1'b0;
    if (bus.BUSY !== 1'b1) busy_drop = 1'b1;
    checkOutput({tag, " latency"}, 32'(k), 32'(exp_lat));
    checkOutput({tag, " result"}, bus.RESULT, exp_res);
    checkOutput({tag, " busy held"}, {31'd0, busy_drop}, 32'd0);
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    checkOutput({tag, " idle after"}, {30'd0, bus.BUSY, bus.DONE}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b);
    wait_done(tag, ref_div(op, a, b), ref_latency(op, a, b), 1'b0);
    check_idle_after(tag);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) seen++;
    end
    checkOutput({tag, " no done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;

    nrst       = 1'b0;
    bus.EN     = 1'b0;
    bus.DIV_OP = 2'b00;
    bus.RS1    = 32'd0;
    bus.RS2    = 32'd0;
`ifdef DIV_FLUSH_EN
    bus.FLUSH  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, bus.BUSY}, 32'd0);
    checkOutput("reset done", {31'd0, bus.DONE}, 32'd0);
    checkOutput("reset result", bus.RESULT, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7);
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0);
    run_op("remu 5/0", OP_REMU, 32'd5, 32'd0);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu ovf-pattern", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    $display("[TB] back-to-back with ignored mid-op start");
    applyStimulus(OP_DIVU, 32'd1000, 32'd3);
    wait_done("b2b first", 32'd333, 34, 1'b0);
    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    checkOutput("b2b setup busy", {31'd0, bus.BUSY}, 32'd1);
    wait_done("b2b second", 32'hFFFF_FFFF, 34, 1'b1);
    check_idle_after("b2b second");

    $display("[TB] reset mid-operation");
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #1 nrst = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, bus.BUSY}, 32'd0);
    checkOutput("abort done", {31'd0, bus.DONE}, 32'd0);
    checkOutput("abort result", bus.RESULT, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    count_dones("abort", 40);

`ifdef DIV_FLUSH_EN
    $display("[TB] flush mid-operation");
    run_op("pre-flush", OP_DIVU, 32'd100, 32'd7);
    applyStimulus(OP_DIV, 32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    bus.FLUSH = 1'b1;
    @(negedge clk);
    bus.FLUSH = 1'b0;
    checkOutput("flush busy", {31'd0, bus.BUSY}, 32'd0);
    checkOutput("flush result", bus.RESULT, 32'd14);
    count_dones("flush", 40);
`endif

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(1, 9)); end
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
